// File: rtl/wts_pkg.sv
// Shared encodings and widths for the wave-table envelope path.
package wts_pkg;

    localparam int W_COUNTER = 20;
    localparam int W_LEVEL   = 7;
    localparam int W_STATE   = 3;
    localparam int W_KEY     = 2;

    typedef enum logic [W_KEY-1:0] {
        KEY_NONE    = 2'b00,
        KEY_ON      = 2'b01,
        KEY_RELEASE = 2'b10,
        KEY_OFF     = 2'b11
    } key_cmd_e;

    typedef enum logic [W_STATE-1:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } eg_state_e;

endpackage

// File: rtl/wts_envelope_sequencer_if.sv
// Bus between the envelope sequencer, the combinational ADSR step stage and the volume stage.
interface wts_envelope_sequencer_if #(
    parameter int CH_BITS = 3
);
    import wts_pkg::*;

    logic [CH_BITS-1:0]   eg_ch;
    logic                 eg_key_on;
    logic                 eg_key_release;
    logic                 eg_key_off;
    logic [W_COUNTER-1:0] eg_counter;
    logic [W_STATE-1:0]   eg_state;
    logic [W_LEVEL-1:0]   eg_level;
    logic [W_COUNTER-1:0] eg_counter_next;
    logic [W_STATE-1:0]   eg_state_next;
    logic [W_LEVEL-1:0]   eg_level_next;
    logic                 lv_valid;
    logic [CH_BITS-1:0]   lv_ch;
    logic [W_LEVEL-1:0]   lv_level;

    modport master (
        output eg_ch, eg_key_on, eg_key_release, eg_key_off,
        output eg_counter, eg_state, eg_level,
        input  eg_counter_next, eg_state_next, eg_level_next,
        output lv_valid, lv_ch, lv_level
    );

    modport slave (
        input  eg_ch, eg_key_on, eg_key_release, eg_key_off,
        input  eg_counter, eg_state, eg_level,
        output eg_counter_next, eg_state_next, eg_level_next,
        input  lv_valid, lv_ch, lv_level
    );

endinterface

// File: rtl/wts_envelope_sequencer_key_latch.sv
// Per-channel pending key commands; a same-clock CPU write beats the service clear.
module wts_key_latch
    import wts_pkg::*;
#(
    parameter int CH_NUM  = 6,
    parameter int CH_BITS = 3
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               active,
    input  logic [CH_BITS-1:0] slot,
    input  logic               key_wr,
    input  logic [CH_BITS-1:0] key_ch,
    input  logic [W_KEY-1:0]   key_cmd,
    output logic               eg_key_on,
    output logic               eg_key_release,
    output logic               eg_key_off
);

    logic [W_KEY-1:0] pending [CH_NUM];
    logic [W_KEY-1:0] cur_cmd;
    logic             wr_legal;

    assign wr_legal = key_wr && (key_cmd != KEY_NONE) && (int'(key_ch) < CH_NUM);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int n = 0; n < CH_NUM; n++) pending[n] <= KEY_NONE;
        end else begin
            for (int n = 0; n < CH_NUM; n++) begin
                if (wr_legal && key_ch == CH_BITS'(n)) begin
                    pending[n] <= key_cmd;
                end else if (active && slot == CH_BITS'(n)) begin
                    pending[n] <= KEY_NONE;
                end
            end
        end
    end

    // Old value is presented this slot even when a write lands on it now.
    always_comb begin
        cur_cmd = KEY_NONE;
        for (int n = 0; n < CH_NUM; n++) begin
            if (active && slot == CH_BITS'(n)) cur_cmd = pending[n];
        end
    end

    assign eg_key_on      = (cur_cmd == KEY_ON);
    assign eg_key_release = (cur_cmd == KEY_RELEASE);
    assign eg_key_off     = (cur_cmd == KEY_OFF);

endmodule

// File: rtl/wts_envelope_sequencer.sv
// Round-robin envelope storage: presents one channel per active clock and writes the step result back.
module wts_envelope_sequencer
    import wts_pkg::*;
#(
    parameter int CH_NUM  = 6,
    parameter int CH_BITS = 3
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     active,
    input  logic                     key_wr,
    input  logic [CH_BITS-1:0]       key_ch,
    input  logic [W_KEY-1:0]         key_cmd,
    wts_envelope_sequencer_if.master eg_bus,
    output logic [CH_NUM-1:0]        ch_busy
);

    logic [W_COUNTER-1:0] counter [CH_NUM];
    logic [W_STATE-1:0]   state   [CH_NUM];
    logic [W_LEVEL-1:0]   level   [CH_NUM];
    logic [CH_BITS-1:0]   slot;
    logic                 lv_valid_q;
    logic [CH_BITS-1:0]   lv_ch_q;
    logic [W_LEVEL-1:0]   lv_level_q;

    wts_key_latch #(
        .CH_NUM  (CH_NUM),
        .CH_BITS (CH_BITS)
    ) u_key_latch (
        .clk            (clk),
        .nreset         (nreset),
        .active         (active),
        .slot           (slot),
        .key_wr         (key_wr),
        .key_ch         (key_ch),
        .key_cmd        (key_cmd),
        .eg_key_on      (eg_bus.eg_key_on),
        .eg_key_release (eg_bus.eg_key_release),
        .eg_key_off     (eg_bus.eg_key_off)
    );

    always_comb begin
        eg_bus.eg_counter = '0;
        eg_bus.eg_state   = '0;
        eg_bus.eg_level   = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            if (slot == CH_BITS'(n)) begin
                eg_bus.eg_counter = counter[n];
                eg_bus.eg_state   = state[n];
                eg_bus.eg_level   = level[n];
            end
        end
    end

    always_comb begin
        ch_busy = '0;
        for (int n = 0; n < CH_NUM; n++) ch_busy[n] = (state[n] != ST_IDLE);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int n = 0; n < CH_NUM; n++) begin
                counter[n] <= '0;
                state[n]   <= '0;
                level[n]   <= '0;
            end
        end else if (active) begin
            for (int n = 0; n < CH_NUM; n++) begin
                if (slot == CH_BITS'(n)) begin
                    counter[n] <= eg_bus.eg_counter_next;
                    state[n]   <= eg_bus.eg_state_next;
                    level[n]   <= eg_bus.eg_level_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            slot       <= '0;
            lv_valid_q <= 1'b0;
            lv_ch_q    <= '0;
            lv_level_q <= '0;
        end else begin
            lv_valid_q <= active;
            if (active) begin
                lv_ch_q    <= slot;
                lv_level_q <= eg_bus.eg_level_next;
                slot       <= (slot == CH_BITS'(CH_NUM - 1)) ? '0 : slot + 1'b1;
            end
        end
    end

    assign eg_bus.eg_ch    = slot;
    assign eg_bus.lv_valid = lv_valid_q;
    assign eg_bus.lv_ch    = lv_ch_q;
    assign eg_bus.lv_level = lv_level_q;

endmodule

// File: tb/tb_wts_envelope_sequencer.sv
// Bench for wts_envelope_sequencer: reference model plus lv_* scoreboard, one task per scenario.
module tb_wts_envelope_sequencer;
    import wts_pkg::*;

    localparam int CH_NUM  = 6;
    localparam int CH_BITS = 3;

    logic               clk     = 1'b0;
    logic               nreset  = 1'b0;
    logic               active  = 1'b0;
    logic               key_wr  = 1'b0;
    logic [CH_BITS-1:0] key_ch  = '0;
    logic [1:0]         key_cmd = 2'b00;
    logic [CH_NUM-1:0]  ch_busy;

    wts_envelope_sequencer_if #(.CH_BITS(CH_BITS)) eg_bus ();

    wts_envelope_sequencer #(.CH_NUM(CH_NUM), .CH_BITS(CH_BITS)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .active  (active),
        .key_wr  (key_wr),
        .key_ch  (key_ch),
        .key_cmd (key_cmd),
        .eg_bus  (eg_bus),
        .ch_busy (ch_busy)
    );

    always #5 clk = ~clk;

    // Step stage stand-in: count up, level +1 saturating at 64, state from key command.
    always_comb begin
        eg_bus.eg_counter_next = eg_bus.eg_counter + 20'd1;
        eg_bus.eg_level_next   = (eg_bus.eg_level >= 7'd64) ? 7'd64 : eg_bus.eg_level + 7'd1;
        eg_bus.eg_state_next   = eg_bus.eg_state;
        if (eg_bus.eg_key_on)           eg_bus.eg_state_next = ST_ATTACK;
        else if (eg_bus.eg_key_release) eg_bus.eg_state_next = ST_RELEASE;
        else if (eg_bus.eg_key_off)     eg_bus.eg_state_next = ST_IDLE;
    end

    typedef struct {int ch; int lvl;} lv_t;
    lv_t  sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   sb_armed = 0;
    bit   exp_valid = 0;

    int         m_cnt  [CH_NUM];
    int         m_lvl  [CH_NUM];
    int         m_st   [CH_NUM];
    logic [1:0] m_pend [CH_NUM];
    int         m_slot;

    function automatic void model_reset();
        for (int n = 0; n < CH_NUM; n++) begin
            m_cnt[n] = 0; m_lvl[n] = 0; m_st[n] = 0; m_pend[n] = 2'b00;
        end
        m_slot = 0;
    endfunction

    function automatic logic [2:0] exp_keys();
        logic [1:0] p;
        p = active ? m_pend[m_slot] : 2'b00;
        return {p == 2'b01, p == 2'b10, p == 2'b11};
    endfunction

    function automatic logic [CH_NUM-1:0] exp_busy();
        logic [CH_NUM-1:0] b;
        for (int n = 0; n < CH_NUM; n++) b[n] = (m_st[n] != 0);
        return b;
    endfunction

    task automatic drive(input logic act, input logic wr, input logic [CH_BITS-1:0] ch, input logic [1:0] cmd);
        @(negedge clk);
        active = act; key_wr = wr; key_ch = ch; key_cmd = cmd;
        #1;
    endtask

    // Advance the model across the coming rising edge and queue the lv_* expectation.
    task automatic tick();
        if (active) begin
            case (m_pend[m_slot])
                2'b01:   m_st[m_slot] = 1;
                2'b10:   m_st[m_slot] = 4;
                2'b11:   m_st[m_slot] = 0;
                default: ;
            endcase
            m_cnt[m_slot] = m_cnt[m_slot] + 1;
            m_lvl[m_slot] = (m_lvl[m_slot] >= 64) ? 64 : m_lvl[m_slot] + 1;
            sb_q.push_back('{m_slot, m_lvl[m_slot]});
            m_pend[m_slot] = 2'b00;
            m_slot = (m_slot == CH_NUM - 1) ? 0 : m_slot + 1;
        end
        if (key_wr && key_cmd != 2'b00 && int'(key_ch) < CH_NUM) m_pend[key_ch] = key_cmd;
        exp_valid = active;
        sb_armed  = 1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_armed) begin
            lv_t e;
            sb_armed = 0;
            n_cmp++;
            if (eg_bus.lv_valid !== exp_valid) begin
                n_err++;
                $display("FAIL lv_valid got %0b want %0b", eg_bus.lv_valid, exp_valid);
            end
            if (exp_valid) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL lv_queue empty got lv_ch %0d", eg_bus.lv_ch);
                end else begin
                    e = sb_q.pop_front();
                    if (eg_bus.lv_ch !== e.ch[CH_BITS-1:0] || eg_bus.lv_level !== e.lvl[6:0]) begin
                        n_err++;
                        $display("FAIL lv_out got ch %0d lvl %0d want ch %0d lvl %0d",
                                 eg_bus.lv_ch, eg_bus.lv_level, e.ch, e.lvl);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [2:0] keys;
        @(negedge clk); #1;
        n_cmp++;
        if ({eg_bus.eg_ch, eg_bus.lv_valid, eg_bus.lv_ch, eg_bus.lv_level, ch_busy, eg_bus.eg_level} !== '0) begin
            n_err++;
            $display("FAIL reset_init got eg_ch %0d lv_valid %0b lv_ch %0d lv_level %0d busy %b want all 0",
                     eg_bus.eg_ch, eg_bus.lv_valid, eg_bus.lv_ch, eg_bus.lv_level, ch_busy);
        end
        @(negedge clk); nreset = 1'b1;
        drive(1'b0, 1'b1, 3'd2, 2'b01); tick();
        drive(1'b1, 1'b0, 3'd0, 2'b00); tick();
        drive(1'b1, 1'b0, 3'd0, 2'b00); tick();
        drive(1'b1, 1'b0, 3'd0, 2'b00);
        n_cmp++;
        if (eg_bus.eg_key_on !== 1'b1 || eg_bus.eg_ch !== 3'd2) begin
            n_err++;
            $display("FAIL reset_pre_on got key_on %0b ch %0d want 1 ch 2", eg_bus.eg_key_on, eg_bus.eg_ch);
        end
        nreset = 1'b0; active = 1'b0; sb_armed = 0; sb_q.delete(); model_reset();
        #1;
        keys = {eg_bus.eg_key_on, eg_bus.eg_key_release, eg_bus.eg_key_off};
        n_cmp++;
        if ({eg_bus.eg_ch, keys, eg_bus.lv_valid, eg_bus.lv_ch, eg_bus.lv_level, ch_busy,
             eg_bus.eg_counter, eg_bus.eg_state, eg_bus.eg_level} !== '0) begin
            n_err++;
            $display("FAIL reset_async got eg_ch %0d keys %b lv_valid %0b lv_ch %0d lv_level %0d busy %b want all 0",
                     eg_bus.eg_ch, keys, eg_bus.lv_valid, eg_bus.lv_ch, eg_bus.lv_level, ch_busy);
        end
        @(negedge clk); nreset = 1'b1;
        for (int i = 0; i < CH_NUM; i++) begin
            drive(1'b1, 1'b0, 3'd0, 2'b00);
            keys = {eg_bus.eg_key_on, eg_bus.eg_key_release, eg_bus.eg_key_off};
            n_cmp++;
            if (keys !== 3'b000 || eg_bus.eg_ch !== 3'(i)) begin
                n_err++;
                $display("FAIL reset_round got ch %0d keys %b want ch %0d keys 000", eg_bus.eg_ch, keys, i);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < CH_NUM + 1; i++) begin
            drive(1'b1, 1'b0, 3'd0, 2'b00);
            n_cmp++;
            if (eg_bus.eg_ch !== 3'(m_slot) || eg_bus.eg_level !== 7'(m_lvl[m_slot]) ||
                eg_bus.eg_counter !== 20'(m_cnt[m_slot])) begin
                n_err++;
                $display("FAIL rr_present got ch %0d lvl %0d cnt %0d want ch %0d lvl %0d cnt %0d",
                         eg_bus.eg_ch, eg_bus.eg_level, eg_bus.eg_counter, m_slot, m_lvl[m_slot], m_cnt[m_slot]);
            end
            tick();
        end
    endtask

    task automatic test_key_on();
        int on_seen = 0;
        logic [2:0] keys;
        while (m_slot != 0) begin drive(1'b1, 1'b0, 3'd0, 2'b00); tick(); end
        drive(1'b1, 1'b1, 3'd3, 2'b01); tick();
        for (int i = 0; i < 2 * CH_NUM; i++) begin
            drive(1'b1, 1'b0, 3'd0, 2'b00);
            keys = {eg_bus.eg_key_on, eg_bus.eg_key_release, eg_bus.eg_key_off};
            n_cmp++;
            if (keys !== exp_keys() || ch_busy !== exp_busy() || eg_bus.eg_state !== 3'(m_st[m_slot])) begin
                n_err++;
                $display("FAIL keyon_step got ch %0d keys %b busy %b want keys %b busy %b",
                         eg_bus.eg_ch, keys, ch_busy, exp_keys(), exp_busy());
            end
            if (eg_bus.eg_key_on) on_seen++;
            tick();
        end
        n_cmp++;
        if (on_seen != 1 || ch_busy[3] !== 1'b1) begin
            n_err++;
            $display("FAIL keyon_once got pulses %0d busy3 %0b want 1 1", on_seen, ch_busy[3]);
        end
    endtask

    task automatic test_collision();
        logic [2:0] keys;
        drive(1'b0, 1'b1, 3'd4, 2'b01); tick();
        while (m_slot != 4) begin drive(1'b1, 1'b0, 3'd0, 2'b00); tick(); end
        drive(1'b1, 1'b1, 3'd4, 2'b10);
        keys = {eg_bus.eg_key_on, eg_bus.eg_key_release, eg_bus.eg_key_off};
        n_cmp++;
        if (keys !== 3'b100) begin
            n_err++;
            $display("FAIL collide_old got keys %b want 100", keys);
        end
        tick();
        for (int i = 0; i < CH_NUM; i++) begin
            drive(1'b1, 1'b0, 3'd0, 2'b00);
            keys = {eg_bus.eg_key_on, eg_bus.eg_key_release, eg_bus.eg_key_off};
            n_cmp++;
            if (keys !== ((m_slot == 4) ? 3'b010 : 3'b000)) begin
                n_err++;
                $display("FAIL collide_new got ch %0d keys %b", eg_bus.eg_ch, keys);
            end
            tick();
        end
    endtask

    task automatic test_gating();
        int held;
        int off_seen = 0;
        logic [2:0] keys;
        drive(1'b0, 1'b1, 3'd1, 2'b11); tick();
        held = m_slot;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 3'd0, 2'b00);
            keys = {eg_bus.eg_key_on, eg_bus.eg_key_release, eg_bus.eg_key_off};
            n_cmp++;
            if (eg_bus.eg_ch !== 3'(held) || keys !== 3'b000 || eg_bus.eg_level !== 7'(m_lvl[held]) ||
                eg_bus.eg_counter !== 20'(m_cnt[held]) || eg_bus.eg_state !== 3'(m_st[held])) begin
                n_err++;
                $display("FAIL gate_hold got ch %0d keys %b lvl %0d cnt %0d want ch %0d keys 000 lvl %0d cnt %0d",
                         eg_bus.eg_ch, keys, eg_bus.eg_level, eg_bus.eg_counter, held, m_lvl[held], m_cnt[held]);
            end
            tick();
        end
        for (int i = 0; i < CH_NUM; i++) begin
            drive(1'b1, 1'b0, 3'd0, 2'b00);
            keys = {eg_bus.eg_key_on, eg_bus.eg_key_release, eg_bus.eg_key_off};
            n_cmp++;
            if (keys !== exp_keys()) begin
                n_err++;
                $display("FAIL gate_resume got ch %0d keys %b want %b", eg_bus.eg_ch, keys, exp_keys());
            end
            if (eg_bus.eg_key_off && eg_bus.eg_ch == 3'd1) off_seen++;
            tick();
        end
        n_cmp++;
        if (off_seen != 1 || ch_busy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL gate_keyoff got pulses %0d busy1 %0b want 1 0", off_seen, ch_busy[1]);
        end
    endtask

    task automatic test_illegal();
        int pulses = 0;
        logic [2:0] keys;
        drive(1'b0, 1'b1, 3'd6, 2'b01); tick();
        drive(1'b0, 1'b1, 3'd7, 2'b11); tick();
        drive(1'b0, 1'b1, 3'd5, 2'b01); tick();
        drive(1'b0, 1'b1, 3'd5, 2'b00); tick();
        drive(1'b0, 1'b1, 3'd0, 2'b00); tick();
        for (int i = 0; i < CH_NUM; i++) begin
            drive(1'b1, 1'b0, 3'd0, 2'b00);
            keys = {eg_bus.eg_key_on, eg_bus.eg_key_release, eg_bus.eg_key_off};
            n_cmp++;
            if (keys !== ((eg_bus.eg_ch == 3'd5) ? 3'b100 : 3'b000)) begin
                n_err++;
                $display("FAIL illegal_keys got ch %0d keys %b", eg_bus.eg_ch, keys);
            end
            if (keys != 3'b000) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL illegal_count got %0d key pulses want 1", pulses);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_key_on();
        test_collision();
        test_gating();
        test_illegal();
        drive(1'b0, 1'b0, 3'd0, 2'b00);
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
